button_ctrl: RTL
================

// Module: button_ctrl
// PURPOSE
//   Upstream control stage for Counter7SD: turns two raw, bouncing, asynchronous
//   push-buttons into the clean pause/reverse level inputs of the counter.
//   Per button: 2-flop synchronizer, debounce filter, press-edge detect and a
//   toggle flop. Each clean press flips the matching output level.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable samples needed to accept a level change (>=2)
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, localparam)
// PORTS
//   clock          in   1  system clock; all state on rising edge
//   reset          in   1  asynchronous, active-low reset (0 = reset)
//   btn_pause      in   1  raw pause button, active-high, asynchronous, bouncing
//   btn_reverse    in   1  raw reverse button, active-high, asynchronous, bouncing
//   pause          out  1  toggle level to Counter7SD.pause; 1 = counter holds
//   reverse        out  1  toggle level to Counter7SD.reverse; 1 = count down
//   pause_press    out  1  one-cycle pulse on each accepted pause press
//   reverse_press  out  1  one-cycle pulse on each accepted reverse press
// BEHAVIOUR
//   - Reset (reset=0, async assert, sync release via clock edge): sync flops,
//     stable levels, counters, pause, reverse, *_press all 0.
//   - Sync: s1<=btn, s2<=s1. Only s2 feeds the filter.
//   - Debounce per button, stable level st and counter cnt:
//       s2==st                   -> cnt<=0
//       s2!=st, cnt<N-1          -> cnt<=cnt+1
//       s2!=st, cnt==N-1         -> st<=s2, cnt<=0   (N = DEBOUNCE_CYCLES)
//     Any sample back at st restarts the count; glitch/bounce shorter than N
//     samples of s2 never reaches st.
//   - Press: rising transition of st (0->1) only. Release (1->0) is filtered
//     identically but produces no pulse and no toggle.
//   - On the edge where st goes 0->1: toggle output flips and *_press is 1 for
//     exactly that following cycle (both registered, same edge).
//   - Latency: with edge k the first edge sampling the new raw level, st,
//     toggle and *_press update at edge k+N+1.
//   - Holding a button: one toggle only; next toggle needs accepted release
//     (N stable low samples) then accepted press.
//   - Buttons fully independent: simultaneous presses toggle both on the same
//     edge; pause does not gate reverse or vice versa.
//   - Counter never wraps: saturating logic bounded at N-1 by the rules above.
//   - Reset asserted mid-debounce or while held: all state cleared; a button
//     still held after release of reset is accepted as a new press after N+2 edges.
// STRUCTURE
//   - Shared package counter7sd_pkg: DEBOUNCE_CYCLES_DEFAULT (16),
//     DEBOUNCE_CYCLES_SIM (4), RESET_ACTIVE (1'b0).
//   - One sub-module btn_debounce (ports clock, reset, btn_raw, level, press),
//     containing sync + filter + edge detect; instantiated twice. Toggle flops
//     live in button_ctrl.
// TESTING  (bench: DEBOUNCE_CYCLES=4, 6-unit clock period, reset pulsed low at start)
//   1 reset=0 with buttons high -> all outputs 0; held after release -> pause=1 at edge k+5.
//   2 btn_pause clean 0->1 held 10 cycles -> pause 0->1 at edge k+5, pause_press high 1 cycle, no second toggle.
//   3 btn_pause bounce 1,0,1,1,0 then steady 1 -> exactly one toggle, 4 clean samples after last bounce.
//   4 btn_reverse 3-cycle glitch high -> reverse stays 0, reverse_press never asserted.
//   5 both buttons pressed same cycle -> pause and reverse flip on same edge; second press pair returns both to 0.
//   6 reset=0 asserted 2 cycles into a debounce -> outputs 0 at once; after release no toggle until raw held N+2 edges.

Source files
------------

// File: rtl/counter7sd_pkg.sv
// Shared constants for the Counter7SD control path.
package counter7sd_pkg;

    localparam int   DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int   DEBOUNCE_CYCLES_SIM     = 4;
    localparam logic RESET_ACTIVE            = 1'b0;

endpackage

// File: rtl/button_ctrl_if.sv
// Button-side bundle: raw buttons in, clean toggle levels and press pulses out.
interface button_ctrl_if;

    // No valid/ready handshake: buttons are raw asynchronous levels, pause/reverse
    // are held levels, *_press are single-cycle strobes, level is the debounced
    // state {reverse, pause} exposed for observation.
    logic       btn_pause;
    logic       btn_reverse;
    logic       pause;
    logic       reverse;
    logic       pause_press;
    logic       reverse_press;
    logic [1:0] level;

    modport master (
        output btn_pause, btn_reverse,
        input  pause, reverse, pause_press, reverse_press, level
    );

    modport slave (
        input  btn_pause, btn_reverse,
        output pause, reverse, pause_press, reverse_press, level
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, saturating debounce filter, rising-edge strobe.
module btn_debounce
    import counter7sd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             accept;

    // press is combinational: high in the cycle before level rises, so the
    // parent can register toggle and pulse on the same edge as level.
    always_comb begin
        accept     = (s2 != level) && (cnt == CNT_MAX);
        cnt_next   = '0;
        level_next = level;
        if (accept) begin
            level_next = s2;
        end else if (s2 != level) begin
            cnt_next = cnt + CNT_W'(1);
        end
        press = accept && s2;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            level <= level_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/button_ctrl.sv
// Debounced pause/reverse toggles feeding Counter7SD.
module button_ctrl
    import counter7sd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    button_ctrl_if.slave bus
);

    logic pause_level;
    logic reverse_level;
    logic pause_rise;
    logic reverse_rise;
    logic pause_q;
    logic reverse_q;
    logic pause_press_q;
    logic reverse_press_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (bus.btn_pause),
        .level   (pause_level),
        .press   (pause_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reverse (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (bus.btn_reverse),
        .level   (reverse_level),
        .press   (reverse_rise)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            pause_q         <= 1'b0;
            reverse_q       <= 1'b0;
            pause_press_q   <= 1'b0;
            reverse_press_q <= 1'b0;
        end else begin
            pause_q         <= pause_q ^ pause_rise;
            reverse_q       <= reverse_q ^ reverse_rise;
            pause_press_q   <= pause_rise;
            reverse_press_q <= reverse_rise;
        end
    end

    assign bus.pause         = pause_q;
    assign bus.reverse       = reverse_q;
    assign bus.pause_press   = pause_press_q;
    assign bus.reverse_press = reverse_press_q;
    assign bus.level         = {reverse_level, pause_level};

endmodule
